square_channel_ctrl: RTL and testbench

Per-channel sequencer that drives the square-wave generator's frequency, duty, volume and enable inputs from Game Boy style NRx0–NRx4 register writes. It contains:
- an internal 512 Hz frame sequencer;
- a length counter;
- a volume envelope;
- a frequency sweep.
It sits between the CPU-side sound register decode and the square-wave generator, in the I_BITCLK domain.

---
 rtl/sq_ctrl_pkg.sv | 50 +++++
 rtl/square_channel_ctrl_if.sv | 11 +
 rtl/sq_frame_sequencer.sv | 57 +++++
 rtl/square_channel_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_square_channel_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sq_ctrl_pkg.sv
// Shared definitions for the square/wave/noise channel controllers:
// register addresses, frame-step masks, envelope/sweep field layouts.
package sq_ctrl_pkg;

    typedef logic [2:0] sq_addr_t;

    localparam sq_addr_t SQ_ADDR_SWEEP   = 3'd0;
    localparam sq_addr_t SQ_ADDR_DUTY    = 3'd1;
    localparam sq_addr_t SQ_ADDR_ENV     = 3'd2;
    localparam sq_addr_t SQ_ADDR_FREQ_LO = 3'd3;
    localparam sq_addr_t SQ_ADDR_TRIG    = 3'd4;

    // Bit n set means the unit is clocked on frame step n.
    localparam logic [7:0] LEN_STEP_MASK   = 8'b0101_0101;
    localparam logic [7:0] SWEEP_STEP_MASK = 8'b0100_0100;
    localparam logic [7:0] ENV_STEP_MASK   = 8'b1000_0000;

    localparam int SQ_LEN_MAX = 64;

    typedef struct packed {
        logic [3:0] init_vol;
        logic       add;
        logic [2:0] period;
    } env_fields_t;

    typedef struct packed {
        logic [2:0] period;
        logic       negate;
        logic [2:0] shift;
    } sweep_fields_t;

    // The DAC is powered whenever the upper five envelope bits are non-zero.
    function automatic logic dac_on(input env_fields_t e);
        return (e.init_vol != 4'h0) || e.add;
    endfunction

    // 12-bit result so that bit 11 flags a period above 2047.
    function automatic logic [11:0] sweep_calc(input logic [10:0] shadow, input sweep_fields_t s);
        logic [11:0] base;
        logic [11:0] delta;
        base  = {1'b0, shadow};
        delta = base >> s.shift;
        return s.negate ? (base - delta) : (base + delta);
    endfunction

    function automatic logic [3:0] sweep_reload(input logic [2:0] period);
        return (period == 3'd0) ? 4'd8 : {1'b0, period};
    endfunction

endpackage

// File: rtl/square_channel_ctrl_if.sv
// CPU-side sound register write bus feeding one channel controller.
interface square_channel_ctrl_if;
    import sq_ctrl_pkg::*;

    logic       I_WR_EN;
    sq_addr_t   I_WR_ADDR;
    logic [7:0] I_WR_DATA;

    modport master (output I_WR_EN, I_WR_ADDR, I_WR_DATA);
    modport slave  (input  I_WR_EN, I_WR_ADDR, I_WR_DATA);
endinterface

// File: rtl/sq_frame_sequencer.sv
// 512 Hz frame sequencer: divider plus 3-bit step counter producing
// one-cycle length/sweep/envelope clock pulses for the entered step.
module sq_frame_sequencer
    import sq_ctrl_pkg::*;
#(
    parameter int FRAME_DIV = 24000
)(
    input  logic       I_BITCLK,
    input  logic       I_RESET,
    output logic [2:0] o_step,
    output logic       o_len_clk,
    output logic       o_sweep_clk,
    output logic       o_env_clk
);

    localparam int               DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_step;
    logic             r_len_clk;
    logic             r_sweep_clk;
    logic             r_env_clk;
    logic [2:0]       w_step_nxt;

    assign w_step_nxt = r_step + 3'd1;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge I_BITCLK) begin
        if (I_RESET) begin
            r_div       <= '0;
            r_step      <= '0;
            r_len_clk   <= 1'b0;
            r_sweep_clk <= 1'b0;
            r_env_clk   <= 1'b0;
        end else begin
            r_len_clk   <= 1'b0;
            r_sweep_clk <= 1'b0;
            r_env_clk   <= 1'b0;
            if (r_div == DIV_LAST) begin
                r_div       <= '0;
                r_step      <= w_step_nxt;
                r_len_clk   <= LEN_STEP_MASK[w_step_nxt];
                r_sweep_clk <= SWEEP_STEP_MASK[w_step_nxt];
                r_env_clk   <= ENV_STEP_MASK[w_step_nxt];
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign o_step      = r_step;
    assign o_len_clk   = r_len_clk;
    assign o_sweep_clk = r_sweep_clk;
    assign o_env_clk   = r_env_clk;

endmodule

// File: rtl/square_channel_ctrl.sv
// Square-channel sequencer: NRx0-NRx4 decode, length counter, envelope and
// frequency sweep. The sweep unit exists only when SQUARE_CTRL_SWEEP_EN is defined.
module square_channel_ctrl
    import sq_ctrl_pkg::*;
#(
    parameter int FRAME_DIV = 24000,
    parameter int LEN_MAX   = SQ_LEN_MAX
)(
    input  logic                 I_BITCLK,
    input  logic                 I_RESET,
    square_channel_ctrl_if.slave i_wr,
    output logic [10:0]          O_FREQUENCY,
    output logic [1:0]           O_DUTY_CYCLE,
    output logic [3:0]           O_VOLUME,
    output logic                 O_WAVEFORM_EN,
    output logic [2:0]           O_FRAME_STEP
);

    logic w_len_clk;
    logic w_sweep_clk;
    logic w_env_clk;

    sq_frame_sequencer #(.FRAME_DIV(FRAME_DIV)) u_frame_seq (
        .I_BITCLK    (I_BITCLK),
        .I_RESET     (I_RESET),
        .o_step      (O_FRAME_STEP),
        .o_len_clk   (w_len_clk),
        .o_sweep_clk (w_sweep_clk),
        .o_env_clk   (w_env_clk)
    );

    logic [1:0]  r_duty;
    logic [6:0]  r_len_cnt;
    logic        r_len_en;
    env_fields_t r_env;
    logic [2:0]  r_env_timer;
    logic [3:0]  r_volume;
    logic [10:0] r_freq;
    logic        r_en;
    logic [3:0]  r_vol_out;

    logic [1:0]  w_duty_nxt;
    logic [6:0]  w_len_cnt_nxt;
    logic        w_len_en_nxt;
    env_fields_t w_env_nxt;
    logic [2:0]  w_env_timer_nxt;
    logic [3:0]  w_volume_nxt;
    logic [10:0] w_freq_nxt;
    logic        w_en_nxt;

    logic        w_trigger;
    env_fields_t w_wr_env;
    logic [10:0] w_trig_freq;

    assign w_trigger   = i_wr.I_WR_EN && (i_wr.I_WR_ADDR == SQ_ADDR_TRIG) && i_wr.I_WR_DATA[7];
    assign w_wr_env    = env_fields_t'(i_wr.I_WR_DATA);
    assign w_trig_freq = {i_wr.I_WR_DATA[2:0], r_freq[7:0]};

`ifdef SQUARE_CTRL_SWEEP_EN
    sweep_fields_t r_sweep;
    logic [3:0]    r_sw_timer;
    logic [10:0]   r_shadow;
    logic          r_sw_active;

    sweep_fields_t w_sweep_nxt;
    logic [3:0]    w_sw_timer_nxt;
    logic [10:0]   w_shadow_nxt;
    logic          w_sw_active_nxt;
    logic          w_sw_wb;
    logic [11:0]   w_sw_calc;
    logic [11:0]   w_sw_recheck;
    logic [11:0]   w_trig_calc;

    assign w_sw_calc    = sweep_calc(r_shadow, r_sweep);
    assign w_sw_recheck = sweep_calc(w_sw_calc[10:0], r_sweep);
    assign w_trig_calc  = sweep_calc(w_trig_freq, r_sweep);
`else
    logic w_unused_sweep_clk;
    assign w_unused_sweep_clk = w_sweep_clk;
`endif

    // NOTE: every next-state variable takes its hold value first, so no latch is inferred.
    always_comb begin
        w_duty_nxt      = r_duty;
        w_len_cnt_nxt   = r_len_cnt;
        w_len_en_nxt    = r_len_en;
        w_env_nxt       = r_env;
        w_env_timer_nxt = r_env_timer;
        w_volume_nxt    = r_volume;
        w_freq_nxt      = r_freq;
        w_en_nxt        = r_en;
`ifdef SQUARE_CTRL_SWEEP_EN
        w_sweep_nxt     = r_sweep;
        w_sw_timer_nxt  = r_sw_timer;
        w_shadow_nxt    = r_shadow;
        w_sw_active_nxt = r_sw_active;
        w_sw_wb         = 1'b0;
`endif

        // A trigger reloads the units itself, so frame clocks in that cycle are dropped.
        if (!w_trigger) begin
            if (w_len_clk && r_len_en && (r_len_cnt != 7'd0)) begin
                w_len_cnt_nxt = r_len_cnt - 7'd1;
                if (r_len_cnt == 7'd1) w_en_nxt = 1'b0;
            end
            if (w_env_clk && (r_env.period != 3'd0)) begin
                if (r_env_timer <= 3'd1) begin
                    w_env_timer_nxt = r_env.period;
                    if (r_env.add && (r_volume != 4'hF))
                        w_volume_nxt = r_volume + 4'd1;
                    else if (!r_env.add && (r_volume != 4'h0))
                        w_volume_nxt = r_volume - 4'd1;
                end else begin
                    w_env_timer_nxt = r_env_timer - 3'd1;
                end
            end
`ifdef SQUARE_CTRL_SWEEP_EN
            if (w_sweep_clk) begin
                if (r_sw_timer <= 4'd1) begin
                    w_sw_timer_nxt = sweep_reload(r_sweep.period);
                    if (r_sw_active && (r_sweep.period != 3'd0)) begin
                        if (w_sw_calc[11]) begin
                            w_en_nxt = 1'b0;
                        end else if (r_sweep.shift != 3'd0) begin
                            w_sw_wb      = 1'b1;
                            w_shadow_nxt = w_sw_calc[10:0];
                            if (w_sw_recheck[11]) w_en_nxt = 1'b0;
                        end
                    end
                end else begin
                    w_sw_timer_nxt = r_sw_timer - 4'd1;
                end
            end
`endif
        end

        if (i_wr.I_WR_EN) begin
            case (i_wr.I_WR_ADDR)
`ifdef SQUARE_CTRL_SWEEP_EN
                SQ_ADDR_SWEEP: w_sweep_nxt = sweep_fields_t'(i_wr.I_WR_DATA[6:0]);
`endif
                SQ_ADDR_DUTY: begin
                    w_duty_nxt    = i_wr.I_WR_DATA[7:6];
                    w_len_cnt_nxt = 7'(LEN_MAX) - {1'b0, i_wr.I_WR_DATA[5:0]};
                end
                SQ_ADDR_ENV: begin
                    w_env_nxt = w_wr_env;
                    if (!dac_on(w_wr_env)) w_en_nxt = 1'b0;
                end
                SQ_ADDR_FREQ_LO: w_freq_nxt[7:0] = i_wr.I_WR_DATA;
                SQ_ADDR_TRIG: begin
                    w_len_en_nxt     = i_wr.I_WR_DATA[6];
                    w_freq_nxt[10:8] = i_wr.I_WR_DATA[2:0];
                    if (i_wr.I_WR_DATA[7]) begin
                        w_en_nxt        = dac_on(r_env);
                        w_volume_nxt    = r_env.init_vol;
                        w_env_timer_nxt = r_env.period;
                        if (r_len_cnt == 7'd0) w_len_cnt_nxt = 7'(LEN_MAX);
`ifdef SQUARE_CTRL_SWEEP_EN
                        w_shadow_nxt    = w_trig_freq;
                        w_sw_timer_nxt  = sweep_reload(r_sweep.period);
                        w_sw_active_nxt = (r_sweep.period != 3'd0) || (r_sweep.shift != 3'd0);
                        if ((r_sweep.shift != 3'd0) && w_trig_calc[11]) w_en_nxt = 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end

`ifdef SQUARE_CTRL_SWEEP_EN
        // Sweep writeback overrides a coincident CPU frequency write.
        if (w_sw_wb) w_freq_nxt = w_sw_calc[10:0];
`endif
    end

    always_ff @(posedge I_BITCLK) begin
        if (I_RESET) begin
            r_duty      <= '0;
            r_len_cnt   <= '0;
            r_len_en    <= 1'b0;
            r_env       <= '0;
            r_env_timer <= '0;
            r_volume    <= '0;
            r_freq      <= '0;
            r_en        <= 1'b0;
            r_vol_out   <= '0;
`ifdef SQUARE_CTRL_SWEEP_EN
            r_sweep     <= '0;
            r_sw_timer  <= '0;
            r_shadow    <= '0;
            r_sw_active <= 1'b0;
`endif
        end else begin
            r_duty      <= w_duty_nxt;
            r_len_cnt   <= w_len_cnt_nxt;
            r_len_en    <= w_len_en_nxt;
            r_env       <= w_env_nxt;
            r_env_timer <= w_env_timer_nxt;
            r_volume    <= w_volume_nxt;
            r_freq      <= w_freq_nxt;
            r_en        <= w_en_nxt;
            r_vol_out   <= w_en_nxt ? w_volume_nxt : 4'h0;
`ifdef SQUARE_CTRL_SWEEP_EN
            r_sweep     <= w_sweep_nxt;
            r_sw_timer  <= w_sw_timer_nxt;
            r_shadow    <= w_shadow_nxt;
            r_sw_active <= w_sw_active_nxt;
`endif
        end
    end

    assign O_FREQUENCY   = r_freq;
    assign O_DUTY_CYCLE  = r_duty;
    assign O_VOLUME      = r_vol_out;
    assign O_WAVEFORM_EN = r_en;

endmodule

// File: tb/tb_square_channel_ctrl.sv
// Bench for square_channel_ctrl: directed scenarios plus random register
// traffic, compared every cycle against a behavioural channel model.
module tb_square_channel_ctrl;

    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] freq;
    logic [1:0]  duty;
    logic [3:0]  vol;
    logic        en;
    logic [2:0]  step;

    int n_vec  = 0;
    int n_miss = 0;

    square_channel_ctrl_if bus_if ();

    square_channel_ctrl #(.FRAME_DIV(FD)) dut (
        .I_BITCLK      (clk),
        .I_RESET       (rst),
        .i_wr          (bus_if),
        .O_FREQUENCY   (freq),
        .O_DUTY_CYCLE  (duty),
        .O_VOLUME      (vol),
        .O_WAVEFORM_EN (en),
        .O_FRAME_STEP  (step)
    );

    always #5 clk = ~clk;

    // Behavioural model state: plain integers, updated once per clock edge.
    int m_edge, m_freq, m_duty, m_vol, m_en, m_len, m_len_en;
    int m_iv, m_add, m_eper, m_etmr;
`ifdef SQUARE_CTRL_SWEEP_EN
    int m_sper, m_neg, m_shift, m_stmr, m_shadow, m_sact;

    function automatic int sweep_new(input int sh);
        return (m_neg != 0) ? sh - (sh >> m_shift) : sh + (sh >> m_shift);
    endfunction
`endif

    function automatic void model_edge(input bit r, input bit we, input int a, input int d);
        bit fc, lclk, eclk, trig;
        int s;
`ifdef SQUARE_CTRL_SWEEP_EN
        bit sclk, sw_wb;
        int nf, sw_freq;
`endif
        if (r) begin
            m_edge = 0; m_freq = 0; m_duty = 0; m_vol = 0; m_en = 0; m_len = 0; m_len_en = 0;
            m_iv = 0; m_add = 0; m_eper = 0; m_etmr = 0;
`ifdef SQUARE_CTRL_SWEEP_EN
            m_sper = 0; m_neg = 0; m_shift = 0; m_stmr = 0; m_shadow = 0; m_sact = 0;
`endif
            return;
        end
        m_edge++;
        // A frame step is entered every FD cycles; its clock acts one edge later.
        fc   = (m_edge > 1) && (((m_edge - 1) % FD) == 0);
        s    = ((m_edge - 1) / FD) % 8;
        lclk = fc && ((s % 2) == 0);
        eclk = fc && (s == 7);
        trig = we && (a == 4) && (d >= 128);
`ifdef SQUARE_CTRL_SWEEP_EN
        sclk  = fc && (s == 2 || s == 6);
        sw_wb = 0;
        sw_freq = 0;
`endif
        if (!trig) begin
            if (lclk && m_len_en != 0 && m_len > 0) begin
                m_len--;
                if (m_len == 0) m_en = 0;
            end
            if (eclk && m_eper != 0) begin
                m_etmr--;
                if (m_etmr <= 0) begin
                    m_etmr = m_eper;
                    if (m_add != 0 && m_vol < 15) m_vol++;
                    else if (m_add == 0 && m_vol > 0) m_vol--;
                end
            end
`ifdef SQUARE_CTRL_SWEEP_EN
            if (sclk) begin
                m_stmr--;
                if (m_stmr <= 0) begin
                    m_stmr = (m_sper == 0) ? 8 : m_sper;
                    if (m_sact != 0 && m_sper != 0) begin
                        nf = sweep_new(m_shadow);
                        if (nf > 2047) m_en = 0;
                        else if (m_shift != 0) begin
                            m_shadow = nf;
                            sw_wb    = 1;
                            sw_freq  = nf;
                            if (sweep_new(nf) > 2047) m_en = 0;
                        end
                    end
                end
            end
`endif
        end
        if (we) begin
            case (a)
`ifdef SQUARE_CTRL_SWEEP_EN
                0: begin m_sper = (d >> 4) & 7; m_neg = (d >> 3) & 1; m_shift = d & 7; end
`endif
                1: begin m_duty = d >> 6; m_len = 64 - (d & 63); end
                2: begin
                    m_iv = d >> 4; m_add = (d >> 3) & 1; m_eper = d & 7;
                    if ((d >> 3) == 0) m_en = 0;
                end
                3: m_freq = (m_freq & 'h700) | d;
                4: begin
                    m_len_en = (d >> 6) & 1;
                    m_freq   = (m_freq & 'hFF) | ((d & 7) << 8);
                    if (trig) begin
                        m_en   = (m_iv != 0 || m_add != 0) ? 1 : 0;
                        m_vol  = m_iv;
                        m_etmr = m_eper;
                        if (m_len == 0) m_len = 64;
`ifdef SQUARE_CTRL_SWEEP_EN
                        m_shadow = m_freq;
                        m_stmr   = (m_sper == 0) ? 8 : m_sper;
                        m_sact   = (m_sper != 0 || m_shift != 0) ? 1 : 0;
                        if (m_shift != 0 && sweep_new(m_shadow) > 2047) m_en = 0;
`endif
                    end
                end
                default: ;
            endcase
        end
`ifdef SQUARE_CTRL_SWEEP_EN
        if (sw_wb) m_freq = sw_freq;
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("freq", 16'(freq), 16'(m_freq));
        check("duty", 16'(duty), 16'(m_duty));
        check("volume", 16'(vol), 16'((m_en != 0) ? m_vol : 0));
        check("enable", 16'(en), 16'(m_en));
        check("step", 16'(step), 16'((m_edge / FD) % 8));
    endtask

    task automatic tick(input logic r, input logic we, input logic [2:0] a, input logic [7:0] d);
        rst              = r;
        bus_if.I_WR_EN   = we;
        bus_if.I_WR_ADDR = a;
        bus_if.I_WR_DATA = d;
        @(posedge clk);
        model_edge(r, we, int'(a), int'(d));
        #1;
        compare_all();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        tick(1'b0, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 3'd0, 8'h00);
        tick(1'b1, 1'b0, 3'd0, 8'h00);
    endtask

    initial begin
        rst              = 1'b1;
        bus_if.I_WR_EN   = 1'b0;
        bus_if.I_WR_ADDR = 3'd0;
        bus_if.I_WR_DATA = 8'h00;

        // Reset state
        do_reset();
        check("rst_freq", 16'(freq), 16'h0);
        check("rst_en", 16'(en), 16'h0);
        check("rst_step", 16'(step), 16'h0);

        // Length: counter 2, enable falls on the second length clock
        wr(3'd2, 8'hF0);
        wr(3'd1, 8'h3E);
        wr(3'd4, 8'hC0);
        check("len_trig_en", 16'(en), 16'h1);
        check("len_trig_vol", 16'(vol), 16'hF);
        idle(40);
        check("len_expired_en", 16'(en), 16'h0);

        // Envelope: decrease every envelope clock, saturate at 0
        do_reset();
        wr(3'd2, 8'hF1);
        wr(3'd4, 8'h80);
        check("env_start_vol", 16'(vol), 16'hF);
        idle(32 * 16 + 40);
        check("env_floor_vol", 16'(vol), 16'h0);
        check("env_floor_en", 16'(en), 16'h1);
        idle(64);
        check("env_nowrap_vol", 16'(vol), 16'h0);

        // Sweep: 0x400 -> 0x600, then overflow recheck
        do_reset();
        wr(3'd0, 8'h11);
        wr(3'd2, 8'hF0);
        wr(3'd3, 8'h00);
        wr(3'd4, 8'h84);
        check("sweep_trig_en", 16'(en), 16'h1);
        idle(40);
`ifdef SQUARE_CTRL_SWEEP_EN
        check("sweep_freq", 16'(freq), 16'h600);
        check("sweep_ovf_en", 16'(en), 16'h0);
`else
        check("sweep_freq", 16'(freq), 16'h400);
        check("sweep_ovf_en", 16'(en), 16'h1);
`endif

        // Overflow detected at trigger time
        do_reset();
        wr(3'd0, 8'h11);
        wr(3'd2, 8'hF0);
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'h87);
`ifdef SQUARE_CTRL_SWEEP_EN
        check("trig_ovf_en", 16'(en), 16'h0);
`else
        check("trig_ovf_en", 16'(en), 16'h1);
`endif

        // DAC off disables, and a later trigger cannot re-enable
        do_reset();
        wr(3'd2, 8'hF0);
        wr(3'd4, 8'h80);
        check("dac_on_en", 16'(en), 16'h1);
        wr(3'd2, 8'h00);
        check("dac_off_en", 16'(en), 16'h0);
        wr(3'd4, 8'h80);
        check("dac_off_trig_en", 16'(en), 16'h0);
        check("dac_off_vol", 16'(vol), 16'h0);

        // Reset mid-envelope together with a trigger write
        do_reset();
        wr(3'd2, 8'hF7);
        wr(3'd1, 8'h80);
        wr(3'd3, 8'h55);
        wr(3'd4, 8'h81);
        idle(50);
        tick(1'b1, 1'b1, 3'd4, 8'h87);
        check("rstwr_freq", 16'(freq), 16'h0);
        check("rstwr_duty", 16'(duty), 16'h0);
        check("rstwr_vol", 16'(vol), 16'h0);
        check("rstwr_en", 16'(en), 16'h0);
        check("rstwr_step", 16'(step), 16'h0);
        idle(1);
        check("rstwr_after_en", 16'(en), 16'h0);
        check("rstwr_after_freq", 16'(freq), 16'h0);

        // Random register traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                tick(1'b1, 1'b0, 3'd0, 8'h00);
            end else if ($urandom_range(0, 3) == 0) begin
                wr(3'($urandom_range(0, 7)), 8'($urandom));
            end else begin
                idle(1);
            end
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
